tiny_dnn_core_seq: RTL

- Control sequencer that sits directly upstream of the per-neuron real-valued MAC core.
- For each sample it issues the control pattern the core expects: one accumulator clear, in_size multiply-accumulate cycles, then one bias add.
- After the core's pipeline drains, it captures the core's sum and hands it downstream on a valid/ready handshake.
- It also drives the address of the external activation buffer, so each input value arrives aligned with the core's weight read.

---
 rtl/tiny_dnn_core_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/tiny_dnn_core_seq.sv
// tiny_dnn_core_seq: control sequencer for the per-neuron MAC core.
// Issues init/exec/bias per sample and hands the core sum downstream.
module tiny_dnn_core_seq #(
    parameter int F_SIZE = 1024,
    parameter int AW     = 10,
    parameter int IAW    = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [AW-1:0]  in_size,
    input  logic [AW-1:0]  n_samples,
    output logic           busy,
    output logic           done,
    output logic           init,
    output logic           exec,
    output logic           bias,
    output logic [AW-1:0]  ra,
    output logic [IAW-1:0] ia,
    input  real            sum,
    output logic           out_valid,
    input  logic           out_ready,
    output real            out_data,
    output logic [AW-1:0]  out_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_EXEC, S_BIAS,
        S_WAIT, S_CAPT, S_OUT,  S_DONE
    } state_t;

    localparam logic [AW-1:0] MAX_SZ = AW'(F_SIZE - 1);

    state_t         state, state_nx;
    logic [AW-1:0]  sz, ns, k, sample;
    logic [IAW-1:0] base;
    logic           last_k, last_s;

    assign last_k = (k == sz - 1'b1);
    assign last_s = (sample == ns - 1'b1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start)
                state_nx = (in_size == '0 || n_samples == '0) ? S_DONE : S_INIT;
            S_INIT: state_nx = S_EXEC;
            S_EXEC: if (last_k) state_nx = S_BIAS;
            S_BIAS: state_nx = S_WAIT;
            S_WAIT: state_nx = S_CAPT;
            S_CAPT: state_nx = S_OUT;
            S_OUT:  if (out_ready) state_nx = last_s ? S_DONE : S_INIT;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control outputs decoded from state; addresses only live in EXEC
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        init      = (state == S_INIT);
        exec      = (state == S_EXEC);
        bias      = (state == S_BIAS);
        out_valid = (state == S_OUT);
        ra        = exec ? k : '0;
        ia        = exec ? base + IAW'(k) : '0;
    end

    // Run parameters, counters and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sz       <= '0;
            ns       <= '0;
            k        <= '0;
            sample   <= '0;
            base     <= '0;
            out_data <= 0.0;
            out_idx  <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    sz     <= (32'(in_size) > F_SIZE - 1) ? MAX_SZ : in_size;
                    ns     <= n_samples;
                    sample <= '0;
                    base   <= '0;
                end
                S_INIT: k <= '0;
                S_EXEC: k <= k + 1'b1;
                S_CAPT: begin
                    out_data <= sum;
                    out_idx  <= sample;
                end
                S_OUT: if (out_ready && !last_s) begin
                    sample <= sample + 1'b1;
                    base   <= base + IAW'(sz);
                end
                default: ;
            endcase
        end
    end

endmodule
